// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point FFT output reorder block.
//   N, LOG2N, DW : FFT length, index width, signed component width
//   IDLE, READ   : read-side FSM encodings
//   complex_t    : packed {re, im} sample as stored in the reorder banks
//   bitrev()     : reverses the LOG2N bits of a sample index
package fft_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 22;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } complex_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] src;
    logic [LOG2N-1:0] res;
    src = idx;
    res = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      res = {res[LOG2N-2:0], src[0]};
      src = src >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One N-entry flop bank for the FFT output reorder buffer.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data ({re, im})
//   raddr : read address (combinational read)
//   rdata : read data
// Contents are intentionally not reset.
module reorder_bank #(
  parameter int N  = 32,
  parameter int AW = 5,
  parameter int W  = 44
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/fft_output_reorder.sv
// Reader end of the 32-point SDF FFT: bit-reversed input, natural-order output.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid           : input sample present this cycle (gaps allowed)
//   data_real_in/imag  : signed sample, bit-reversed order
//   out_valid          : output sample valid (N-cycle gap-free burst per frame)
//   data_real_out/imag : signed sample, natural order (0 when idle)
//   out_index          : natural frequency index of the output sample
//   frame_done         : pulse with the last sample (index N-1) of a frame
module fft_output_reorder #(
  parameter int N     = fft_pkg::N,
  parameter int LOG2N = fft_pkg::LOG2N,
  parameter int DW    = fft_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] data_real_in,
  input  logic signed [DW-1:0] data_imag_in,
  output logic                 out_valid,
  output logic signed [DW-1:0] data_real_out,
  output logic signed [DW-1:0] data_imag_out,
  output logic [LOG2N-1:0]     out_index,
  output logic                 frame_done
);

  import fft_pkg::*;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;
  logic             wsel;
  logic             rsel;
  logic [0:0]       state;

  logic             complete;
  logic             we0;
  logic             we1;
  logic [LOG2N-1:0] waddr;
  logic [LOG2N-1:0] raddr;
  logic             rbank;
  logic [2*DW-1:0]  wdata;
  logic [2*DW-1:0]  rdata0;
  logic [2*DW-1:0]  rdata1;
  complex_t         rword;

  // The completion edge itself acts as "start": the read port is steered to
  // entry 0 of the bank just filled so X[0] registers on that same edge,
  // giving one-cycle latency. rcnt then holds the next index to emit.
  always_comb begin
    complete = in_valid && (wcnt == LAST);
    we0      = in_valid && !rst && !wsel;
    we1      = in_valid && !rst && wsel;
    waddr    = bitrev(wcnt);
    wdata    = {data_real_in, data_imag_in};
    raddr    = complete ? '0 : rcnt;
    rbank    = complete ? wsel : rsel;
    rword    = rbank ? complex_t'(rdata1) : complex_t'(rdata0);
  end

  reorder_bank #(
    .N  (N),
    .AW (LOG2N),
    .W  (2*DW)
  ) u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata0)
  );

  reorder_bank #(
    .N  (N),
    .AW (LOG2N),
    .W  (2*DW)
  ) u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt          <= '0;
      rcnt          <= '0;
      wsel          <= 1'b0;
      rsel          <= 1'b0;
      state         <= IDLE;
      out_valid     <= 1'b0;
      frame_done    <= 1'b0;
      data_real_out <= '0;
      data_imag_out <= '0;
      out_index     <= '0;
    end else begin
      if (in_valid) begin
        wcnt <= wcnt + 1'b1;
      end
      if (complete) begin
        wsel <= ~wsel;
        rsel <= wsel;
      end

      if (complete) begin
        // A completion never coincides with a pending read sample: the
        // previous burst ended on the edge before, so this is back-to-back.
        state         <= READ;
        rcnt          <= LOG2N'(1);
        out_valid     <= 1'b1;
        frame_done    <= (LAST == '0);
        out_index     <= '0;
        data_real_out <= rword.re;
        data_imag_out <= rword.im;
      end else if (state == READ) begin
        out_valid     <= 1'b1;
        frame_done    <= (rcnt == LAST);
        out_index     <= rcnt;
        data_real_out <= rword.re;
        data_imag_out <= rword.im;
        rcnt          <= rcnt + 1'b1;
        if (rcnt == LAST) begin
          state <= IDLE;
        end
      end else begin
        out_valid     <= 1'b0;
        frame_done    <= 1'b0;
        out_index     <= '0;
        data_real_out <= '0;
        data_imag_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
module tb_fft_output_reorder;

  localparam int N  = 32;
  localparam int DW = 22;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] data_real_in = '0;
  logic signed [DW-1:0] data_imag_in = '0;
  logic                 out_valid;
  logic signed [DW-1:0] data_real_out;
  logic signed [DW-1:0] data_imag_out;
  logic [4:0]           out_index;
  logic                 frame_done;

  fft_output_reorder #(
    .N     (32),
    .LOG2N (5),
    .DW    (22)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .data_real_in  (data_real_in),
    .data_imag_in  (data_imag_in),
    .out_valid     (out_valid),
    .data_real_out (data_real_out),
    .data_imag_out (data_imag_out),
    .out_index     (out_index),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   cyc;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [4:0]           idx;
    logic                 done;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic signed [DW-1:0] nat_re [N];
  logic signed [DW-1:0] nat_im [N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] brev(input logic [4:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every cycle either an expected sample is due and must
  // appear exactly then, or the outputs must be idle zeros.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("sample_missing_late", 64'(sb[0].cyc), 64'(cyc));
      void'(sb.pop_front());
    end
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
        chk("out_real", 64'(data_real_out), 64'(e.re));
        chk("out_imag", 64'(data_imag_out), 64'(e.im));
        chk("out_index", 64'(out_index), 64'(e.idx));
        chk("frame_done", 64'(frame_done), 64'(e.done));
      end
    end else begin
      chk("idle_outputs", {frame_done, out_index, data_real_out, data_imag_out},
          64'(0));
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        chk("out_valid_gap", 64'(out_valid), 64'(1));
        void'(sb.pop_front());
      end
    end
  end

  task automatic push_frame(input int base);
    exp_t e;
    for (int n = 0; n < N; n++) begin
      e.cyc  = base + 1 + n;
      e.re   = nat_re[n];
      e.im   = nat_im[n];
      e.idx  = 5'(n);
      e.done = (n == N - 1);
      sb.push_back(e);
    end
  endtask

  // Drives nat_re/nat_im in bit-reversed order; leaves in_valid high after
  // the last sample so frames can be chained without a gap.
  task automatic send_frame(input bit gapped);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      data_real_in = nat_re[brev(5'(k))];
      data_imag_in = nat_im[brev(5'(k))];
      if (k == N - 1) push_frame(cyc);
      if (gapped && k != N - 1) begin
        @(negedge clk);
        in_valid     = 1'b0;
        data_real_in = '0;
        data_imag_in = '0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid     = 1'b0;
      data_real_in = '0;
      data_imag_in = '0;
    end
  endtask

  initial begin
    int hit;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_index", 64'(out_index), 64'(0));
    chk("rst_data", {data_real_out, data_imag_out}, 64'(0));
    rst = 1'b0;
    idle(2);

    // One continuous frame: real = 3n, imag = -n in natural order
    for (int n = 0; n < N; n++) begin
      nat_re[n] = DW'(3 * n);
      nat_im[n] = DW'(-n);
    end
    send_frame(1'b0);
    idle(40);

    // Same frame with in_valid toggling every cycle
    send_frame(1'b1);
    idle(40);

    // Three back-to-back frames, real = 100f + n
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < N; n++) begin
        nat_re[n] = DW'(100 * f + n);
        nat_im[n] = DW'(f - n);
      end
      send_frame(1'b0);
    end
    idle(40);

    // Extreme values at natural index 20 only
    for (int n = 0; n < N; n++) begin
      nat_re[n] = '0;
      nat_im[n] = '0;
    end
    nat_re[20] = -(DW'(1) <<< 21);
    nat_im[20] = (DW'(1) <<< 21) - DW'(1);
    send_frame(1'b0);
    idle(40);

    // Reset after 17 inputs: partial frame discarded
    for (int n = 0; n < N; n++) begin
      nat_re[n] = DW'(7 * n - 50);
      nat_im[n] = DW'(n * n);
    end
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      data_real_in = DW'(999);
      data_imag_in = DW'(-999);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(40);
    chk("midframe_rst_no_output", 64'(sb.size()), 64'(0));
    send_frame(1'b0);
    idle(40);

    // Reset during a read burst at out_index 10
    for (int n = 0; n < N; n++) begin
      nat_re[n] = DW'(1000 + n);
      nat_im[n] = DW'(-2000 - n);
    end
    send_frame(1'b0);
    idle(1);
    hit = 0;
    for (int i = 0; i < 100 && hit == 0; i++) begin
      if (out_valid === 1'b1 && out_index === 5'd10) hit = 1;
      else @(negedge clk);
    end
    chk("burst_reached_idx10", 64'(hit), 64'(1));
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("burst_rst_drop", 64'(out_valid), 64'(0));
    rst = 1'b0;
    idle(40);
    chk("burst_rst_stays_idle", 64'(out_valid), 64'(0));

    // Fresh frame after the burst reset
    for (int n = 0; n < N; n++) begin
      nat_re[n] = DW'(-n * 11);
      nat_im[n] = DW'(n + 5);
    end
    send_frame(1'b0);
    idle(1);
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Reader end of the 32-point single-path-delay FFT pipeline.
- Accepts complex results from the last butterfly stage, which arrive in bit-reversed index order. Stores them in a ping-pong buffer and streams them out in natural order X[0]..X[N-1].
- The write side tolerates gaps on in_valid. The read side emits a frame as a gap-free burst of N cycles.

Parameters:
- N, 32, FFT length in samples; must be a power of 2.
- LOG2N, 5, log2(N); width of the sample counters and indices.
- DW, 22, signed width of the real and imag parts.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data_real_in/data_imag_in hold a pipeline result this cycle.
- data_real_in  in  DW  signed real part, bit-reversed order.
- data_imag_in  in  DW  signed imag part, bit-reversed order.
- out_valid  out  1  output sample valid.
- data_real_out  out  DW  signed real part, natural order.
- data_imag_out  out  DW  signed imag part, natural order.
- out_index  out  LOG2N  natural frequency index of the current output sample.
- frame_done  out  1  one-cycle pulse together with the last sample (index N-1) of a frame.

Behaviour:
- Storage: two banks, each N entries of 2*DW bits, built from flops. wsel selects the write bank; rsel selects the read bank.
- Write side: wcnt counts 0..N-1.
  - A cycle with in_valid=1 writes bank[wsel][bitrev(wcnt)], then wcnt+1.
  - A cycle with in_valid=0 holds wcnt and writes nothing.
  - bitrev reverses the LOG2N bits of wcnt. Example for N=32: wcnt=1 goes to entry 16, wcnt=3 to entry 24.
- Frame completion: the edge on which wcnt=N-1 and in_valid=1 is the completion edge.
  - On that edge wcnt wraps to 0, wsel toggles, rsel loads the old wsel, and start is raised.
- Read FSM has two states, IDLE and READ.
  - IDLE: on start, go to READ with rcnt=0.
  - READ: each cycle the output registers load bank[rsel][rcnt], out_valid=1, out_index=rcnt, then rcnt+1.
  - READ, rcnt=N-1: frame_done=1. If start is also pending, stay in READ, reload rcnt=0 with the new rsel, and run back-to-back with no gap. Otherwise go to IDLE.
- Latency: the first output sample X[0] is valid in the cycle immediately after the completion edge. Each frame's output occupies exactly N consecutive cycles.
- No overflow possible: a frame needs at least N write cycles and the read of the other bank takes exactly N cycles. The read of bank k therefore always finishes before bank k is written again. No in_ready is needed.
- Outputs outside READ:
  - out_valid=0 and frame_done=0.
  - data_real_out, data_imag_out and out_index are driven to 0.
- Values pass through bit-exact: no scaling, rounding or sign change.
- Reset on any edge with rst=1:
  - wcnt=0, rcnt=0, wsel=0, rsel=0, FSM=IDLE.
  - out_valid=0, frame_done=0, all data outputs and out_index=0.
  - Bank contents are not cleared.
- Reset mid-frame: any partially written or partially read frame is discarded, with no further out_valid for it. The next in_valid sample after reset is treated as wcnt=0.
- Simultaneous completion and last read: handled by the back-to-back rule above.

Decomposition:
- Shared package fft_pkg holds: constants N, LOG2N, DW; a complex_t typedef (signed real/imag, DW each); a bitrev function over LOG2N bits.
- Sub-module reorder_bank: one N x 2*DW flop bank with a write port (we, waddr, wdata) and a combinational read port (raddr, rdata). Instantiated twice.

Test Plan:
- Reset then one frame: in_valid held high for 32 cycles with real = bitrev(k)*3 and imag = -bitrev(k) for the k-th sample -> out_valid is high for 32 cycles starting 1 cycle after the last input. Output n has real=3n, imag=-n, out_index=n, and frame_done on n=31.
- Gapped input: same frame with in_valid toggling 1/0 every cycle (64 cycles total) -> identical natural-order output burst, starting 1 cycle after the 32nd valid sample.
- Back-to-back frames: 3 frames of 96 continuous valid cycles, frame f carrying real=100f+bitrev(k) -> 96 continuous out_valid cycles with real=100f+n. No gap between frames and frame_done at cycles 31, 63 and 95 of the burst.
- Extremes: real=-2^21 and imag=2^21-1 at bit-reversed position 5 (natural index 20), all others 0 -> only out_index=20 carries those exact values. No sign corruption.
- Reset mid-operation: assert rst for 1 cycle after 17 inputs of frame 0 -> no output for frame 0. A fresh 32-sample frame then reorders correctly with first output index 0.
- Reset during a read burst at out_index=10 -> out_valid drops the cycle after the reset edge and all outputs read 0 until the next frame completes.
